// File: rtl/control_mascota.sv
// ---------------------------------------------------------------------------
// control_mascota
//
// Central controller for the pet's four need modes (animo, energia,
// descanso, medicina). It reads the four 2-bit need levels every cycle and
// keeps a registered pet state. From that state it decodes the mode-enable
// strobes. It also runs the decay scheduler, which hands one decrement pulse
// at a time to the modes in round-robin order.
//
// Parameters:
//   TICKS_DECAY     clock cycles between decay slots in normal mode
//                   (must be >= 2*TEST_DIV)
//   TEST_DIV        speed-up divisor applied while test=1
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-high, clears all state
//   test            debounced test-mode level, 1 selects fast decay
//   nivel_animo     animo level 0..3
//   nivel_energia   energia level 0..3
//   nivel_descanso  descanso level 0..3
//   nivel_medicina  medicina level 0..3
//   estado          registered pet state
//   activo_comida   feed enable for the energia mode
//   activo_medicina medicine enable for the medicina mode
//   dec_pulse       one-hot 1-cycle decay strobe
//                   (bit0 animo, bit1 energia, bit2 descanso, bit3 medicina)
//
// Configuration macro:
//   MASCOTA_MUERTE_EN  when defined, compiles in the sticky MUERTO state
//                      (three or more empty needs). When undefined,
//                      encoding 5 is treated as illegal and decay never stops.
// ---------------------------------------------------------------------------
module control_mascota #(
   parameter int TICKS_DECAY = 50_000_000,
   parameter int TEST_DIV    = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       test,
   input  logic [1:0] nivel_animo,
   input  logic [1:0] nivel_energia,
   input  logic [1:0] nivel_descanso,
   input  logic [1:0] nivel_medicina,
   output logic [2:0] estado,
   output logic       activo_comida,
   output logic       activo_medicina,
   output logic [3:0] dec_pulse
);

   typedef enum logic [2:0] {
      NORMAL     = 3'd0,
      HAMBRIENTO = 3'd1,
      TRISTE     = 3'd2,
      ENFERMO    = 3'd3,
      DORMIDO    = 3'd4,
      MUERTO     = 3'd5
   } estado_t;

   // The prescaler must be able to hold TICKS_DECAY-1; one extra bit of
   // headroom keeps power-of-two settings safe.
   localparam int CW = $clog2(TICKS_DECAY + 1);

   // Compare values are stored as terminal-minus-one so the compare is a
   // plain >= against the running count.
   localparam logic [CW-1:0] TERM_NORMAL_M1 = CW'(TICKS_DECAY - 1);
   localparam logic [CW-1:0] TERM_TEST_M1   = CW'((TICKS_DECAY / TEST_DIV) - 1);

   estado_t        estado_q;
   estado_t        estado_d;
   logic           estado_legal;
   logic           muerte_cond;

   logic [CW-1:0]  cnt_q;
   logic [1:0]     ptr_q;
   logic [CW-1:0]  term_m1;
   logic           alcanzado;
   logic           congelado;
   logic [3:0]     pulso_d;

   // Death condition: three or more of the four needs have run dry. Only
   // built when the feature is enabled, so the default build carries no
   // unused zero counter.
`ifdef MASCOTA_MUERTE_EN
   logic [2:0] ceros;

   always_comb begin
      ceros = 3'(nivel_animo == 2'd0)
            + 3'(nivel_energia == 2'd0)
            + 3'(nivel_descanso == 2'd0)
            + 3'(nivel_medicina == 2'd0);
      muerte_cond = (ceros >= 3'd3);
   end
`else
   assign muerte_cond = 1'b0;
`endif

   // Legal-encoding check on the registered state. Anything outside the
   // enumerated set (including MUERTO when death is compiled out) is
   // treated as corrupted and pulled back to NORMAL on the next cycle.
   always_comb begin
      estado_legal = 1'b0;
      case (estado_q)
         NORMAL, HAMBRIENTO, TRISTE, ENFERMO, DORMIDO: estado_legal = 1'b1;
`ifdef MASCOTA_MUERTE_EN
         MUERTO:                                        estado_legal = 1'b1;
`endif
         default:                                       estado_legal = 1'b0;
      endcase
   end

   // State register. The state is the only thing the display logic sees, so
   // it resets straight to NORMAL.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q <= NORMAL;
      end else begin
         estado_q <= estado_d;
      end
   end

   // Next-state selection, fixed priority from the top. DORMIDO has
   // hysteresis: once asleep the pet stays asleep until descanso is full
   // again, but hunger, sickness and death still wake it up because they
   // are checked first.
   always_comb begin
      estado_d = NORMAL;
      if (!estado_legal) begin
         estado_d = NORMAL;
      end else if (muerte_cond || (estado_q == MUERTO)) begin
         estado_d = MUERTO;
      end else if (nivel_medicina == 2'd0) begin
         estado_d = ENFERMO;
      end else if (nivel_energia == 2'd0) begin
         estado_d = HAMBRIENTO;
      end else if ((nivel_descanso == 2'd0) ||
                   ((estado_q == DORMIDO) && (nivel_descanso != 2'd3))) begin
         estado_d = DORMIDO;
      end else if (nivel_animo == 2'd0) begin
         estado_d = TRISTE;
      end else begin
         estado_d = NORMAL;
      end
   end

   // Enable decode straight from the registered state, so the enables move
   // in the same cycle as estado. Illegal encodings enable nothing.
   always_comb begin
      activo_comida   = 1'b0;
      activo_medicina = 1'b0;
      case (estado_q)
         NORMAL, HAMBRIENTO, TRISTE: activo_comida   = 1'b1;
         ENFERMO:                    activo_medicina = 1'b1;
         default: begin
            activo_comida   = 1'b0;
            activo_medicina = 1'b0;
         end
      endcase
   end

   assign estado = estado_q;

   // Decay compare. The terminal is chosen from the live test level, so a
   // switch into fast mode with the count already past the new terminal
   // fires on the very next edge. A dead pet freezes the scheduler. While
   // asleep the descanso slot is still consumed (pointer advances) but its
   // strobe is suppressed so rest does not drain.
   always_comb begin
      term_m1   = test ? TERM_TEST_M1 : TERM_NORMAL_M1;
      alcanzado = (cnt_q >= term_m1);
`ifdef MASCOTA_MUERTE_EN
      congelado = (estado_q == MUERTO);
`else
      congelado = 1'b0;
`endif
      pulso_d = 4'b0000;
      if (alcanzado && !congelado &&
          !((estado_q == DORMIDO) && (ptr_q == 2'd2))) begin
         pulso_d[ptr_q] = 1'b1;
      end
   end

   // Prescaler, slot pointer and registered strobe. The strobe is always
   // cleared on the cycle after a fire because the count restarts at zero
   // and the terminal is at least two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         ptr_q     <= 2'd0;
         dec_pulse <= 4'b0000;
      end else if (congelado) begin
         dec_pulse <= 4'b0000;
      end else if (alcanzado) begin
         cnt_q     <= '0;
         ptr_q     <= ptr_q + 2'd1;
         dec_pulse <= pulso_d;
      end else begin
         cnt_q     <= cnt_q + CW'(1);
         dec_pulse <= 4'b0000;
      end
   end

endmodule
